// File: rtl/stepgen_bank_pkg.sv
// remora_pkg: shared constants, defaults and helpers for the step
// generator bank and its per-joint channels.
package remora_pkg;

    localparam int FREQ_W = 32;
    localparam int CNT_W  = 10;

    localparam int DEF_NUM_JOINTS       = 5;
    localparam int DEF_ACC_WIDTH        = 32;
    localparam int DEF_PULSE_CYCLES     = 48;
    localparam int DEF_DIR_SETUP_CYCLES = 48;

    localparam logic [FREQ_W-1:0] FREQ_MIN = 32'h8000_0000;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 32'h7fff_ffff;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } step_state_e;

    // |f| of a signed word; the most negative value saturates
    function automatic logic [FREQ_W-1:0] freq_mag(
        input logic [FREQ_W-1:0] f
    );
        logic [FREQ_W-1:0] m;
        m = f;
        if (f[FREQ_W-1])
            m = (f == FREQ_MIN) ? FREQ_MAX : (~f + 1'b1);
        return m;
    endfunction

endpackage

// File: rtl/stepgen_bank_if.sv
// stepgen_bank_if: per-joint link between the bank (shadowed command)
// and one stepgen_channel (pins and feedback).
interface stepgen_bank_if;
    import remora_pkg::*;

    logic [FREQ_W-1:0] freq;
    logic              en;
    logic              stp;
    logic              dir;
    logic              overrun;
    logic [FREQ_W-1:0] feedback;

    modport master (
        output freq, en,
        input  stp, dir, overrun, feedback
    );

    modport slave (
        input  freq, en,
        output stp, dir, overrun, feedback
    );

endinterface

// File: rtl/stepgen_bank_channel.sv
// stepgen_channel: one joint -- phase accumulator, step/dir pulse FSM
// with one-deep pending request, and the step-position counter.
module stepgen_channel
    import remora_pkg::*;
#(
    parameter int ACC_WIDTH        = DEF_ACC_WIDTH,
    parameter int PULSE_CYCLES     = DEF_PULSE_CYCLES,
    parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
) (
    input  logic          i_clk,
    input  logic          i_rst,
    stepgen_bank_if.slave bus
);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(DIR_SETUP_CYCLES - 1);

    step_state_e         r_state;
    step_state_e         w_state_nx;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nx;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH:0]  w_sum;
    logic [FREQ_W-1:0]   w_mag;
    logic [FREQ_W-1:0]   r_count;
    logic [FREQ_W-1:0]   r_fb;
    logic                r_pend;
    logic                w_pend_nx;
    logic                r_ovr;
    logic                w_ovr_nx;
    logic                r_dir;
    logic                w_dir_nx;
    logic                r_stp;
    logic                w_step;
    logic                w_req;
    logic                w_req_dir;
    logic                w_decide;
    logic                w_serve;

    assign w_mag     = freq_mag(bus.freq);
    assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH + 1)'(w_mag);
    assign w_req     = bus.en & w_sum[ACC_WIDTH];
    assign w_req_dir = ~bus.freq[FREQ_W-1];

    // last LOW cycle decides like IDLE so a pending step costs no gap
    assign w_decide = (r_state == ST_IDLE)
                    | ((r_state == ST_LOW) & (r_cnt == '0));
    assign w_serve  = bus.en & w_decide & (r_pend | w_req);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pend_nx  = r_pend;
        w_ovr_nx   = r_ovr;
        w_dir_nx   = r_dir;
        w_step     = 1'b0;

        if (!bus.en) begin
            w_pend_nx = 1'b0;
        end else if (w_decide) begin
            w_pend_nx = r_pend & w_req;
        end else if (w_req) begin
            if (r_pend)
                w_ovr_nx = 1'b1;
            else
                w_pend_nx = 1'b1;
        end

        if (w_serve) begin
            w_dir_nx = w_req_dir;
            if (w_req_dir == r_dir) begin
                w_state_nx = ST_HIGH;
                w_cnt_nx   = PULSE_LAST;
                w_step     = 1'b1;
            end else begin
                w_state_nx = ST_SETUP;
                w_cnt_nx   = SETUP_LAST;
            end
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_cnt_nx = '0;
                end
                ST_SETUP: begin
                    if (r_cnt == '0) begin
                        w_state_nx = ST_HIGH;
                        w_cnt_nx   = PULSE_LAST;
                        w_step     = 1'b1;
                    end else begin
                        w_cnt_nx = r_cnt - 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (r_cnt == '0) begin
                        w_state_nx = ST_LOW;
                        w_cnt_nx   = PULSE_LAST;
                    end else begin
                        w_cnt_nx = r_cnt - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (r_cnt == '0)
                        w_state_nx = ST_IDLE;
                    else
                        w_cnt_nx = r_cnt - 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_pend  <= 1'b0;
            r_ovr   <= 1'b0;
            r_dir   <= 1'b1;
            r_stp   <= 1'b0;
            r_count <= '0;
            r_fb    <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pend  <= w_pend_nx;
            r_ovr   <= w_ovr_nx;
            r_dir   <= w_dir_nx;
            r_stp   <= (w_state_nx == ST_HIGH);
            r_fb    <= r_count;
            if (bus.en)
                r_acc <= w_sum[ACC_WIDTH-1:0];
            // dir is already settled whenever HIGH is entered
            if (w_step)
                r_count <= r_dir ? r_count + 1'b1 : r_count - 1'b1;
        end
    end

    assign bus.stp      = r_stp;
    assign bus.dir      = r_dir;
    assign bus.overrun  = r_ovr;
    assign bus.feedback = r_fb;

endmodule

// File: rtl/stepgen_bank.sv
// stepgen_bank: command shadow registers plus NUM_JOINTS step/dir
// channels, with packing of the per-joint words.
module stepgen_bank
    import remora_pkg::*;
#(
    parameter int NUM_JOINTS       = DEF_NUM_JOINTS,
    parameter int ACC_WIDTH        = DEF_ACC_WIDTH,
    parameter int PULSE_CYCLES     = DEF_PULSE_CYCLES,
    parameter int DIR_SETUP_CYCLES = DEF_DIR_SETUP_CYCLES
) (
    input  logic                         sysclk,
    input  logic                         rst,
    input  logic                         cmd_valid,
    input  logic [NUM_JOINTS*FREQ_W-1:0] freq_cmd,
    input  logic [NUM_JOINTS-1:0]        joint_enable,
    input  logic                         error,
    output logic [NUM_JOINTS*FREQ_W-1:0] joint_feedback,
    output logic [NUM_JOINTS-1:0]        stp,
    output logic [NUM_JOINTS-1:0]        dir,
    output logic [NUM_JOINTS-1:0]        overrun
);

    logic [NUM_JOINTS*FREQ_W-1:0] r_freq;
    logic [NUM_JOINTS-1:0]        r_en;

    always_ff @(posedge sysclk) begin
        if (rst) begin
            r_freq <= '0;
            r_en   <= '0;
        end else if (cmd_valid) begin
            r_freq <= freq_cmd;
            r_en   <= joint_enable;
        end
    end

    for (genvar j = 0; j < NUM_JOINTS; j++) begin : g_ch
        stepgen_bank_if link ();

        assign link.freq = r_freq[j*FREQ_W +: FREQ_W];
        assign link.en   = r_en[j] & ~error;

        stepgen_channel #(
            .ACC_WIDTH        (ACC_WIDTH),
            .PULSE_CYCLES     (PULSE_CYCLES),
            .DIR_SETUP_CYCLES (DIR_SETUP_CYCLES)
        ) u_ch (
            .i_clk (sysclk),
            .i_rst (rst),
            .bus   (link)
        );

        assign stp[j]     = link.stp;
        assign dir[j]     = link.dir;
        assign overrun[j] = link.overrun;
        assign joint_feedback[j*FREQ_W +: FREQ_W] = link.feedback;
    end

endmodule

// File: tb/tb_stepgen_bank.sv
// tb_stepgen_bank: directed and random command frames against a
// timestamp-based reference model of every joint.
module tb_stepgen_bank;

    localparam int NJ = 8;
    localparam int A  = 32;
    localparam int P  = 48;
    localparam int D  = 48;
    localparam longint ACC_MOD = 64'd1 << A;

    logic              sysclk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic [NJ*32-1:0]  freq_cmd;
    logic [NJ-1:0]     joint_enable;
    logic              error;
    logic [NJ*32-1:0]  joint_feedback;
    logic [NJ-1:0]     stp;
    logic [NJ-1:0]     dir;
    logic [NJ-1:0]     overrun;

    stepgen_bank #(
        .NUM_JOINTS       (NJ),
        .ACC_WIDTH        (A),
        .PULSE_CYCLES     (P),
        .DIR_SETUP_CYCLES (D)
    ) dut (
        .sysclk         (sysclk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .freq_cmd       (freq_cmd),
        .joint_enable   (joint_enable),
        .error          (error),
        .joint_feedback (joint_feedback),
        .stp            (stp),
        .dir            (dir),
        .overrun        (overrun)
    );

    always #5 sysclk = ~sysclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag,
                       input logic [NJ*32-1:0] got,
                       input logic [NJ*32-1:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    endtask

    // reference model: per-joint phase, pulse time windows, pending
    longint      cyc = 0;
    longint      m_phase [NJ];
    logic [31:0] m_shf   [NJ];
    bit          m_she   [NJ];
    bit          m_pend  [NJ];
    bit          m_ovr   [NJ];
    bit          m_dir   [NJ];
    bit          m_stp   [NJ];
    logic [31:0] m_cnt   [NJ];
    logic [31:0] m_fb    [NJ];
    longint      m_free  [NJ];
    longint      m_hs    [NJ];
    longint      m_he    [NJ];
    longint      m_cedge [NJ];
    int          m_delta [NJ];

    task automatic model_edge();
        for (int j = 0; j < NJ; j++) begin
            longint mag;
            longint sum;
            longint setup;
            bit en;
            bit req;
            bit srv;
            bit nd;
            logic [31:0] f;
            if (rst) begin
                m_phase[j] = 0;  m_shf[j] = '0;  m_she[j] = 0;
                m_pend[j]  = 0;  m_ovr[j] = 0;   m_dir[j] = 1;
                m_stp[j]   = 0;  m_cnt[j] = '0;  m_fb[j]  = '0;
                m_free[j]  = 0;  m_hs[j]  = -1;  m_he[j]  = -2;
                m_cedge[j] = -1; m_delta[j] = 0;
            end else begin
                f  = m_shf[j];
                en = m_she[j] && !error;
                if (f == 32'h8000_0000)
                    mag = 64'h7fff_ffff;
                else if (f[31])
                    mag = 0 - longint'($signed(f));
                else
                    mag = longint'(f);
                sum = m_phase[j] + mag;
                req = en && (sum >= ACC_MOD);
                if (en)
                    m_phase[j] = sum % ACC_MOD;
                if (cyc >= m_free[j]) begin
                    srv = en && (m_pend[j] || req);
                    m_pend[j] = en && m_pend[j] && req;
                    if (srv) begin
                        nd = !f[31];
                        setup = (nd != m_dir[j]) ? D : 0;
                        m_dir[j]   = nd;
                        m_hs[j]    = cyc + setup;
                        m_he[j]    = m_hs[j] + P - 1;
                        m_free[j]  = m_hs[j] + 2 * P;
                        m_cedge[j] = m_hs[j];
                        m_delta[j] = nd ? 1 : -1;
                    end
                end else if (!en) begin
                    m_pend[j] = 0;
                end else if (req) begin
                    if (m_pend[j])
                        m_ovr[j] = 1;
                    else
                        m_pend[j] = 1;
                end
                m_fb[j] = m_cnt[j];
                if (m_cedge[j] == cyc)
                    m_cnt[j] = m_cnt[j] + 32'(m_delta[j]);
                m_stp[j] = (cyc >= m_hs[j]) && (cyc <= m_he[j]);
                if (cmd_valid) begin
                    m_shf[j] = freq_cmd[j*32 +: 32];
                    m_she[j] = joint_enable[j];
                end
            end
        end
        cyc++;
    endtask

    task automatic compare();
        logic [NJ*32-1:0] e_fb;
        logic [NJ-1:0] e_stp;
        logic [NJ-1:0] e_dir;
        logic [NJ-1:0] e_ovr;
        for (int j = 0; j < NJ; j++) begin
            e_fb[j*32 +: 32] = m_fb[j];
            e_stp[j] = m_stp[j];
            e_dir[j] = m_dir[j];
            e_ovr[j] = m_ovr[j];
        end
        chk("stp", {{(NJ*31){1'b0}}, stp}, {{(NJ*31){1'b0}}, e_stp});
        chk("dir", {{(NJ*31){1'b0}}, dir}, {{(NJ*31){1'b0}}, e_dir});
        chk("overrun", {{(NJ*31){1'b0}}, overrun},
            {{(NJ*31){1'b0}}, e_ovr});
        chk("feedback", joint_feedback, e_fb);
    endtask

    task automatic tick();
        @(posedge sysclk);
        model_edge();
        #1;
        compare();
        @(negedge sysclk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    // non-strobe cycles carry junk that the shadows must ignore
    task automatic send(input logic [NJ*32-1:0] f,
                        input logic [NJ-1:0] en);
        cmd_valid    = 1'b1;
        freq_cmd     = f;
        joint_enable = en;
        tick();
        cmd_valid = 1'b0;
        for (int j = 0; j < NJ; j++)
            freq_cmd[j*32 +: 32] = $urandom;
        joint_enable = NJ'($urandom);
    endtask

    function automatic logic [31:0] rnd_freq();
        int k;
        logic [31:0] m;
        k = $urandom_range(0, 11);
        if (k == 0)
            return 32'h8000_0000;
        if (k == 1)
            return 32'h0;
        m = 32'($urandom_range(1, 255)) << $urandom_range(16, 23);
        if ($urandom_range(0, 1) == 1)
            m = ~m + 1'b1;
        return m;
    endfunction

    logic [NJ*32-1:0] fv;

    initial begin
        rst          = 1'b1;
        cmd_valid    = 1'b0;
        freq_cmd     = '0;
        joint_enable = '0;
        error        = 1'b0;
        @(negedge sysclk);
        run(2);
        rst = 1'b0;
        run(3);

        // distinct per-joint rates and signs
        for (int j = 0; j < NJ; j++) begin
            fv[j*32 +: 32] = 32'((j + 1) << 22);
            if (j % 2 == 1)
                fv[j*32 +: 32] = ~fv[j*32 +: 32] + 1'b1;
        end
        fv[31:0] = 32'h0100_0000;
        send(fv, '1);
        run(2700);

        // reverse joint 0, then overdrive joint 1
        fv[31:0] = 32'hff00_0000;
        send(fv, '1);
        run(1500);
        fv[63:32] = 32'h4000_0000;
        send(fv, '1);
        run(400);

        // global stop mid-pulse, then resume from held phase
        while (stp[0] !== 1'b1)
            tick();
        run(10);
        error = 1'b1;
        run(600);
        error = 1'b0;
        run(1200);

        // reset mid-pulse collides with a command strobe
        while (stp[2] !== 1'b1)
            tick();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        tick();
        rst       = 1'b0;
        cmd_valid = 1'b0;
        run(300);

        for (int fr = 0; fr < 30; fr++) begin
            for (int j = 0; j < NJ; j++)
                fv[j*32 +: 32] = rnd_freq();
            send(fv, NJ'($urandom));
            for (int i = 0; i < $urandom_range(200, 1400); i++) begin
                if ($urandom_range(0, 299) == 0)
                    error = ~error;
                rst = ($urandom_range(0, 3999) == 0);
                tick();
            end
            rst   = 1'b0;
            error = 1'b0;
        end
        run(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
